rv32_hazard_ctrl: RTL and testbench
===================================

// Module: rv32_hazard_ctrl
// PURPOSE
//  Parametrised hazard/forwarding controller for the RV32I pipeline (IF/ID/EX/MEM/WB and deeper variants).
//  Tracks in-flight destination registers in a scoreboard shift register and registers per-operand forward selects for EX.
//  Raises load-use stalls, branch flushes and a global freeze on data-memory back-pressure.
//  Replaces the constant-zero forward_control_src1/src2 registers in the CPU top.
// PARAMETERS
//  REG_AW     5  register address width
//  FWD_STAGES 2  forwardable stages past EX (1=MEM, 2=WB, ...); scoreboard depth; range 1..6
//  LOAD_LAT   1  stages after MEM before load data is forwardable; range 0..FWD_STAGES-1
//  SEL_W      3  forward-select width, must satisfy 2**SEL_W > FWD_STAGES
//  CNT_W      32 stall performance counter width
// PORTS
//  clk              in  1      pipeline clock, rising edge
//  rst_n            in  1      asynchronous reset, active low
//  id_valid         in  1      ID holds a live instruction
//  id_rs1_addr      in  REG_AW rs1 of ID instruction
//  id_rs2_addr      in  REG_AW rs2 of ID instruction
//  id_rs1_used      in  1      ID instruction reads rs1
//  id_rs2_used      in  1      ID instruction reads rs2
//  id_rd_addr       in  REG_AW rd of ID instruction
//  id_reg_write     in  1      ID instruction writes rd
//  id_is_load       in  1      ID instruction is a load
//  ex_branch_taken  in  1      EX resolved a taken branch/jump
//  mem_ready        in  1      data memory accepts/returns this cycle; 0 = back-pressure
//  stall_if         out 1      hold PC
//  stall_id         out 1      hold IF/ID register
//  freeze           out 1      hold ID/EX, EX/MEM, MEM/WB registers
//  flush_id         out 1      squash IF/ID contents
//  bubble_ex        out 1      load NOP into ID/EX
//  fwd_sel_src1     out SEL_W  registered EX operand-1 select: 0=regfile, k=result of stage k past EX
//  fwd_sel_src2     out SEL_W  as above, operand 2
//  stall_cycles     out CNT_W  saturating count of cycles with stall_if=1
// BEHAVIOUR
//  Scoreboard slot[j], j=0..FWD_STAGES-1: {valid, rd, reg_write, is_load}; slot0 = instruction in EX.
//  Match(j, rs): slot[j].valid & reg_write & rd==rs & rs!=0 & operand used. Youngest (lowest j) match wins.
//  Forward select: at ID, winning j gives next sel = j+1; no match gives 0; registered into fwd_sel_* on clk.
//  Load-use: winning match with is_load and j < LOAD_LAT -> load_use=1 (LOAD_LAT=0: never stalls).
//  Priority per cycle: freeze > branch flush > load-use stall > normal advance.
//   freeze = ~mem_ready: stall_if=stall_id=freeze=1; scoreboard, fwd_sel, outputs held; flush_id=bubble_ex=0.
//   flush = ex_branch_taken & mem_ready: flush_id=1, bubble_ex=1, stall_*=0; load_use ignored; next slot0 invalid, fwd_sel<=0.
//   stall = load_use & id_valid & mem_ready & ~flush: stall_if=stall_id=1, bubble_ex=1; next slot0 invalid, fwd_sel<=0.
//   advance: slot0<=ID fields (valid=id_valid), fwd_sel<=computed selects.
//  Scoreboard shifts slot[j]<=slot[j-1] every non-freeze cycle; slot[FWD_STAGES-1] retires (regfile must write-before-read).
//  stall_cycles increments whenever stall_if=1 (freeze or load-use); saturates at all-ones, no wrap.
//  Stall/flush/freeze/bubble outputs combinational from scoreboard and inputs; fwd_sel_* and stall_cycles registered.
//  Reset (async, any time incl. mid-stall): all slots invalid, fwd_sel_*=0, stall_cycles=0; with mem_ready=1 all stall/flush outputs 0.
//  Branch instruction itself stays in scoreboard (may write rd, e.g. JAL) and keeps forwarding.
// STRUCTURE
//  rv32_pipe_pkg: slot record typedef, FWD_REGFILE=0 encoding, max FWD_STAGES, priority-enum constants.
//  One sub-module rv32_hazard_cmp: per-operand priority match over slots -> {hit, sel, is_load_hit}; instanced twice.
//  Scoreboard, select registers, counter and priority logic in top.
// TESTING
//  add x5 then add x6,x5 back-to-back -> fwd_sel_src1=1 in consumer EX cycle, no stall.
//  add x5; nop; sub x7,x0,x5 -> fwd_sel_src2=2; FWD_STAGES=2 with 3 gaps -> sel 0 (regfile).
//  lw x5 then add x6,x5,x5 (LOAD_LAT=1) -> one cycle stall_if=stall_id=bubble_ex=1, then both sel=2; stall_cycles=1.
//  rd=x0 producer, consumer reads x0 -> sel 0, no stall; dual match x5 in slot0 and slot1 -> sel 1.
//  ex_branch_taken with load-use pending -> flush_id=1, stall_if=0, next fwd_sel=0.
//  mem_ready low 3 cycles mid load-use -> all held, stall_cycles +3; rst_n low mid-stall -> slots/sel/counter cleared.

Source files
------------

// File: rtl/rv32_pipe_pkg.sv
// Shared pipeline-control types for the RV32I hazard controller.
//  - hz_slot_t   : one scoreboard entry describing an in-flight instruction
//  - hz_action_e : per-cycle pipeline action, listed from lowest to highest priority
//  - FWD_REGFILE : forward-select encoding meaning "take operand from regfile"
package rv32_pipe_pkg;

    // Deepest supported forwarding network (stages past EX).
    localparam int MAX_FWD_STAGES = 6;
    // Slot rd field is sized for the widest register address we support;
    // narrower REG_AW values are zero-extended into it.
    localparam int MAX_REG_AW     = 8;
    localparam int FWD_REGFILE    = 0;

    typedef struct packed {
        logic                  valid;
        logic [MAX_REG_AW-1:0] rd;
        logic                  reg_write;
        logic                  is_load;
    } hz_slot_t;

    typedef enum logic [1:0] {
        HZ_ADVANCE = 2'd0,
        HZ_STALL   = 2'd1,
        HZ_FLUSH   = 2'd2,
        HZ_FREEZE  = 2'd3
    } hz_action_e;

endpackage

// File: rtl/rv32_hazard_cmp.sv
// Per-operand dependency comparator.
// Scans the scoreboard for the youngest in-flight writer of rs and reports
// whether one exists, which forward select it maps to, and whether it is a load.
// Ports:
//  slots       in  FWD_STAGES scoreboard entries, slot 0 = instruction in EX
//  rs          in  REG_AW     source register read by the ID instruction
//  used        in  1          ID instruction actually reads rs
//  hit         out 1          a live writer of rs was found
//  sel         out SEL_W      forward select (winning slot index + 1), 0 when no hit
//  is_load_hit out 1          the winning writer is a load
module rv32_hazard_cmp
    import rv32_pipe_pkg::*;
#(
    parameter int FWD_STAGES = 2,
    parameter int REG_AW     = 5,
    parameter int SEL_W      = 3
) (
    input  hz_slot_t          slots [FWD_STAGES],
    input  logic [REG_AW-1:0] rs,
    input  logic              used,
    output logic              hit,
    output logic [SEL_W-1:0]  sel,
    output logic              is_load_hit
);

    logic [MAX_REG_AW-1:0] rs_ext;
    logic                  rs_live;

    assign rs_ext  = MAX_REG_AW'(rs);
    // x0 is hard-wired zero, so it never has a producer worth forwarding.
    assign rs_live = used && (rs != '0);

    // Walk from oldest to youngest so the youngest matching slot is the
    // last assignment and therefore wins.
    always_comb begin
        hit         = 1'b0;
        sel         = SEL_W'(FWD_REGFILE);
        is_load_hit = 1'b0;
        for (int j = FWD_STAGES - 1; j >= 0; j--) begin
            if (rs_live && slots[j].valid && slots[j].reg_write &&
                (slots[j].rd == rs_ext)) begin
                hit         = 1'b1;
                sel         = SEL_W'(j + 1);
                is_load_hit = slots[j].is_load;
            end
        end
    end

endmodule

// File: rtl/rv32_hazard_ctrl.sv
// Hazard / forwarding controller for the RV32I pipeline.
// Keeps a scoreboard of destination registers in flight past ID, registers
// per-operand forward selects for EX, and raises load-use stalls, branch
// flushes and a global freeze while data memory back-pressures.
//
// mem_ready handshake: mem_ready=1 means data memory accepted/returned its
// access this cycle and the pipeline may move; mem_ready=0 means it did not,
// so every pipeline register (and all state here) holds unchanged.
//
// Ports:
//  clk, rst_n            clock (rising edge), asynchronous active-low reset
//  id_valid              ID holds a live instruction
//  id_rs1_addr/rs2_addr  source registers of the ID instruction
//  id_rs1_used/rs2_used  ID instruction reads rs1/rs2
//  id_rd_addr            destination of the ID instruction
//  id_reg_write          ID instruction writes rd
//  id_is_load            ID instruction is a load
//  ex_branch_taken       EX resolved a taken branch/jump
//  mem_ready             data memory progress (0 = back-pressure)
//  stall_if, stall_id    hold PC / IF-ID register
//  freeze                hold ID/EX, EX/MEM, MEM/WB registers
//  flush_id              squash IF/ID contents
//  bubble_ex             load NOP into ID/EX
//  fwd_sel_src1/src2     registered EX operand selects: 0=regfile, k=stage k past EX
//  stall_cycles          saturating count of cycles with stall_if=1
module rv32_hazard_ctrl
    import rv32_pipe_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int FWD_STAGES = 2,
    parameter int LOAD_LAT   = 1,
    parameter int SEL_W      = 3,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic              id_reg_write,
    input  logic              id_is_load,
    input  logic              ex_branch_taken,
    input  logic              mem_ready,
    output logic              stall_if,
    output logic              stall_id,
    output logic              freeze,
    output logic              flush_id,
    output logic              bubble_ex,
    output logic [SEL_W-1:0]  fwd_sel_src1,
    output logic [SEL_W-1:0]  fwd_sel_src2,
    output logic [CNT_W-1:0]  stall_cycles
);

    hz_slot_t   slots [FWD_STAGES];
    hz_slot_t   new_slot;
    hz_action_e action;

    logic             hit1, hit2;
    logic             load_hit1, load_hit2;
    logic [SEL_W-1:0] sel1, sel2;
    logic             load_use;

    rv32_hazard_cmp #(
        .FWD_STAGES (FWD_STAGES),
        .REG_AW     (REG_AW),
        .SEL_W      (SEL_W)
    ) u_cmp_rs1 (
        .slots       (slots),
        .rs          (id_rs1_addr),
        .used        (id_rs1_used),
        .hit         (hit1),
        .sel         (sel1),
        .is_load_hit (load_hit1)
    );

    rv32_hazard_cmp #(
        .FWD_STAGES (FWD_STAGES),
        .REG_AW     (REG_AW),
        .SEL_W      (SEL_W)
    ) u_cmp_rs2 (
        .slots       (slots),
        .rs          (id_rs2_addr),
        .used        (id_rs2_used),
        .hit         (hit2),
        .sel         (sel2),
        .is_load_hit (load_hit2)
    );

    // A load in slot j has its data forwardable only from stage LOAD_LAT+1
    // onward, i.e. a hit with sel <= LOAD_LAT is too early. With LOAD_LAT=0
    // every hit has sel >= 1, so this never fires.
    assign load_use = (hit1 && load_hit1 && (sel1 <= SEL_W'(LOAD_LAT))) ||
                      (hit2 && load_hit2 && (sel2 <= SEL_W'(LOAD_LAT)));

    // Priority: freeze > branch flush > load-use stall > advance.
    always_comb begin
        action = HZ_ADVANCE;
        if (!mem_ready) begin
            action = HZ_FREEZE;
        end else if (ex_branch_taken) begin
            action = HZ_FLUSH;
        end else if (load_use && id_valid) begin
            action = HZ_STALL;
        end
    end

    assign freeze    = (action == HZ_FREEZE);
    assign stall_if  = (action == HZ_FREEZE) || (action == HZ_STALL);
    assign stall_id  = stall_if;
    assign flush_id  = (action == HZ_FLUSH);
    assign bubble_ex = (action == HZ_FLUSH) || (action == HZ_STALL);

    // The ID instruction only enters the scoreboard when it actually moves
    // into EX; flush and stall both inject a bubble instead.
    always_comb begin
        new_slot = '0;
        if (action == HZ_ADVANCE) begin
            new_slot.valid     = id_valid;
            new_slot.rd        = MAX_REG_AW'(id_rd_addr);
            new_slot.reg_write = id_reg_write;
            new_slot.is_load   = id_is_load;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < FWD_STAGES; j++) begin
                slots[j] <= '0;
            end
            fwd_sel_src1 <= SEL_W'(FWD_REGFILE);
            fwd_sel_src2 <= SEL_W'(FWD_REGFILE);
        end else if (action != HZ_FREEZE) begin
            slots[0] <= new_slot;
            // Oldest slot falls off the end; the regfile writes before it
            // is read, so no forwarding is needed beyond this depth.
            for (int j = 1; j < FWD_STAGES; j++) begin
                slots[j] <= slots[j-1];
            end
            if (action == HZ_ADVANCE) begin
                fwd_sel_src1 <= sel1;
                fwd_sel_src2 <= sel2;
            end else begin
                fwd_sel_src1 <= SEL_W'(FWD_REGFILE);
                fwd_sel_src2 <= SEL_W'(FWD_REGFILE);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (stall_if && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_rv32_hazard_ctrl.sv
// Directed bench for rv32_hazard_ctrl (FWD_STAGES=2, LOAD_LAT=1).
// Inputs change 1 time unit after the rising edge; combinational outputs are
// checked on the falling edge, registered outputs 1 unit after the rising edge.
// A second instance with a 3-bit stall counter shares all inputs so counter
// saturation can be observed in a short run.
module tb_rv32_hazard_ctrl;

    localparam int REG_AW = 5;
    localparam int SEL_W  = 3;
    localparam int CNT_W  = 32;
    localparam int SAT_W  = 3;

    logic              clk;
    logic              rst_n;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1_addr;
    logic [REG_AW-1:0] id_rs2_addr;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [REG_AW-1:0] id_rd_addr;
    logic              id_reg_write;
    logic              id_is_load;
    logic              ex_branch_taken;
    logic              mem_ready;
    logic              stall_if;
    logic              stall_id;
    logic              freeze;
    logic              flush_id;
    logic              bubble_ex;
    logic [SEL_W-1:0]  fwd_sel_src1;
    logic [SEL_W-1:0]  fwd_sel_src2;
    logic [CNT_W-1:0]  stall_cycles;

    logic              s_stall_if;
    logic              s_stall_id;
    logic              s_freeze;
    logic              s_flush_id;
    logic              s_bubble_ex;
    logic [SEL_W-1:0]  s_fwd_sel_src1;
    logic [SEL_W-1:0]  s_fwd_sel_src2;
    logic [SAT_W-1:0]  sat_cycles;

    int pass_cnt;
    int chk_cnt;
    int exp_stall;
    int exp_sat;

    rv32_hazard_ctrl #(
        .REG_AW(REG_AW), .FWD_STAGES(2), .LOAD_LAT(1), .SEL_W(SEL_W), .CNT_W(CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_rs1_addr     (id_rs1_addr),
        .id_rs2_addr     (id_rs2_addr),
        .id_rs1_used     (id_rs1_used),
        .id_rs2_used     (id_rs2_used),
        .id_rd_addr      (id_rd_addr),
        .id_reg_write    (id_reg_write),
        .id_is_load      (id_is_load),
        .ex_branch_taken (ex_branch_taken),
        .mem_ready       (mem_ready),
        .stall_if        (stall_if),
        .stall_id        (stall_id),
        .freeze          (freeze),
        .flush_id        (flush_id),
        .bubble_ex       (bubble_ex),
        .fwd_sel_src1    (fwd_sel_src1),
        .fwd_sel_src2    (fwd_sel_src2),
        .stall_cycles    (stall_cycles)
    );

    rv32_hazard_ctrl #(
        .REG_AW(REG_AW), .FWD_STAGES(2), .LOAD_LAT(1), .SEL_W(SEL_W), .CNT_W(SAT_W)
    ) dut_sat (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_rs1_addr     (id_rs1_addr),
        .id_rs2_addr     (id_rs2_addr),
        .id_rs1_used     (id_rs1_used),
        .id_rs2_used     (id_rs2_used),
        .id_rd_addr      (id_rd_addr),
        .id_reg_write    (id_reg_write),
        .id_is_load      (id_is_load),
        .ex_branch_taken (ex_branch_taken),
        .mem_ready       (mem_ready),
        .stall_if        (s_stall_if),
        .stall_id        (s_stall_id),
        .freeze          (s_freeze),
        .flush_id        (s_flush_id),
        .bubble_ex       (s_bubble_ex),
        .fwd_sel_src1    (s_fwd_sel_src1),
        .fwd_sel_src2    (s_fwd_sel_src2),
        .stall_cycles    (sat_cycles)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_id(input logic v, input int rd, input int rs1, input int rs2,
                          input logic u1, input logic u2, input logic we, input logic ld);
        id_valid     = v;
        id_rd_addr   = REG_AW'(rd);
        id_rs1_addr  = REG_AW'(rs1);
        id_rs2_addr  = REG_AW'(rs2);
        id_rs1_used  = u1;
        id_rs2_used  = u2;
        id_reg_write = we;
        id_is_load   = ld;
    endtask

    task automatic nop();
        set_id(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic alu(input int rd, input int rs1, input int rs2);
        set_id(1'b1, rd, rs1, rs2, 1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic load(input int rd, input int rs1);
        set_id(1'b1, rd, rs1, 0, 1'b1, 1'b0, 1'b1, 1'b1);
    endtask

    // Two bubbles retire everything from a 2-deep scoreboard.
    task automatic drain();
        nop(); tick();
        nop(); tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (2) @(posedge clk);
        mid();
        chk_cnt++; if (fwd_sel_src1 !== 3'd0) $display("FAIL rst_sel1: got %0d want 0", fwd_sel_src1); else pass_cnt++;
        chk_cnt++; if (fwd_sel_src2 !== 3'd0) $display("FAIL rst_sel2: got %0d want 0", fwd_sel_src2); else pass_cnt++;
        chk_cnt++; if (stall_cycles !== 32'd0) $display("FAIL rst_cnt: got %0d want 0", stall_cycles); else pass_cnt++;
        chk_cnt++; if ({stall_if, stall_id, freeze, flush_id, bubble_ex} !== 5'b0)
            $display("FAIL rst_ctl: got %b want 00000", {stall_if, stall_id, freeze, flush_id, bubble_ex}); else pass_cnt++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        drain();
        alu(5, 1, 2); tick();
        alu(6, 5, 1);
        mid();
        chk_cnt++; if (stall_if !== 1'b0) $display("FAIL b2b_nostall: got %b want 0", stall_if); else pass_cnt++;
        tick();
        chk_cnt++; if (fwd_sel_src1 !== 3'd1) $display("FAIL b2b_sel1: got %0d want 1", fwd_sel_src1); else pass_cnt++;
        chk_cnt++; if (fwd_sel_src2 !== 3'd0) $display("FAIL b2b_sel2: got %0d want 0", fwd_sel_src2); else pass_cnt++;
        // Same producer, consumer does not read rs1: no forwarding.
        drain();
        alu(5, 1, 2); tick();
        set_id(1'b1, 6, 5, 3, 1'b0, 1'b1, 1'b1, 1'b0); tick();
        chk_cnt++; if (fwd_sel_src1 !== 3'd0) $display("FAIL unused_sel1: got %0d want 0", fwd_sel_src1); else pass_cnt++;
    endtask

    task automatic test_gap();
        drain();
        alu(5, 1, 2); tick();
        nop(); tick();
        alu(7, 0, 5); tick();
        chk_cnt++; if (fwd_sel_src2 !== 3'd2) $display("FAIL gap1_sel2: got %0d want 2", fwd_sel_src2); else pass_cnt++;
        chk_cnt++; if (fwd_sel_src1 !== 3'd0) $display("FAIL gap1_sel1: got %0d want 0", fwd_sel_src1); else pass_cnt++;
        // Producer retired from the scoreboard: read the regfile.
        drain();
        alu(5, 1, 2); tick();
        nop(); tick();
        nop(); tick();
        alu(7, 0, 5); tick();
        chk_cnt++; if (fwd_sel_src2 !== 3'd0) $display("FAIL gap2_sel2: got %0d want 0", fwd_sel_src2); else pass_cnt++;
    endtask

    task automatic test_load_use();
        drain();
        load(5, 1); tick();
        alu(6, 5, 5);
        mid();
        chk_cnt++; if ({stall_if, stall_id, bubble_ex, flush_id, freeze} !== 5'b11100)
            $display("FAIL lu_ctl: got %b want 11100", {stall_if, stall_id, bubble_ex, flush_id, freeze}); else pass_cnt++;
        tick();
        exp_stall++;
        chk_cnt++; if (fwd_sel_src1 !== 3'd0) $display("FAIL lu_bubble_sel: got %0d want 0", fwd_sel_src1); else pass_cnt++;
        chk_cnt++; if (stall_cycles !== 32'(exp_stall)) $display("FAIL lu_cnt: got %0d want %0d", stall_cycles, exp_stall); else pass_cnt++;
        mid();
        chk_cnt++; if (stall_if !== 1'b0) $display("FAIL lu_release: got %b want 0", stall_if); else pass_cnt++;
        tick();
        chk_cnt++; if (fwd_sel_src1 !== 3'd2) $display("FAIL lu_sel1: got %0d want 2", fwd_sel_src1); else pass_cnt++;
        chk_cnt++; if (fwd_sel_src2 !== 3'd2) $display("FAIL lu_sel2: got %0d want 2", fwd_sel_src2); else pass_cnt++;
        chk_cnt++; if (stall_cycles !== 32'(exp_stall)) $display("FAIL lu_cnt2: got %0d want %0d", stall_cycles, exp_stall); else pass_cnt++;
    endtask

    task automatic test_x0_and_dual();
        drain();
        alu(0, 1, 2); tick();
        alu(6, 0, 0); tick();
        chk_cnt++; if (fwd_sel_src1 !== 3'd0) $display("FAIL x0_sel1: got %0d want 0", fwd_sel_src1); else pass_cnt++;
        load(0, 1); tick();
        alu(6, 0, 0);
        mid();
        chk_cnt++; if (stall_if !== 1'b0) $display("FAIL x0_load_nostall: got %b want 0", stall_if); else pass_cnt++;
        drain();
        alu(5, 1, 2); tick();
        alu(5, 3, 4); tick();
        alu(6, 5, 2); tick();
        chk_cnt++; if (fwd_sel_src1 !== 3'd1) $display("FAIL dual_sel1: got %0d want 1", fwd_sel_src1); else pass_cnt++;
        chk_cnt++; if (fwd_sel_src2 !== 3'd0) $display("FAIL dual_sel2: got %0d want 0", fwd_sel_src2); else pass_cnt++;
    endtask

    task automatic test_branch_flush();
        drain();
        load(5, 1); tick();
        alu(6, 5, 5);
        ex_branch_taken = 1'b1;
        mid();
        chk_cnt++; if ({flush_id, bubble_ex, stall_if, stall_id, freeze} !== 5'b11000)
            $display("FAIL br_ctl: got %b want 11000", {flush_id, bubble_ex, stall_if, stall_id, freeze}); else pass_cnt++;
        tick();
        ex_branch_taken = 1'b0;
        chk_cnt++; if (fwd_sel_src1 !== 3'd0) $display("FAIL br_sel1: got %0d want 0", fwd_sel_src1); else pass_cnt++;
        chk_cnt++; if (stall_cycles !== 32'(exp_stall)) $display("FAIL br_cnt: got %0d want %0d", stall_cycles, exp_stall); else pass_cnt++;
        // A jump writing x1 keeps forwarding after it flushes the wrong path.
        drain();
        set_id(1'b1, 1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
        set_id(1'b1, 9, 1, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        ex_branch_taken = 1'b1;
        tick();
        ex_branch_taken = 1'b0;
        set_id(1'b1, 10, 1, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        chk_cnt++; if (fwd_sel_src1 !== 3'd2) $display("FAIL jal_fwd: got %0d want 2", fwd_sel_src1); else pass_cnt++;
    endtask

    task automatic test_freeze();
        drain();
        alu(5, 1, 2); tick();
        load(8, 5); tick();
        chk_cnt++; if (fwd_sel_src1 !== 3'd1) $display("FAIL frz_pre_sel: got %0d want 1", fwd_sel_src1); else pass_cnt++;
        alu(6, 8, 8);
        mem_ready = 1'b0;
        mid();
        chk_cnt++; if ({freeze, stall_if, stall_id, bubble_ex, flush_id} !== 5'b11100)
            $display("FAIL frz_ctl: got %b want 11100", {freeze, stall_if, stall_id, bubble_ex, flush_id}); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_cnt++; if (fwd_sel_src1 !== 3'd1) $display("FAIL frz_hold_sel cyc%0d: got %0d want 1", i, fwd_sel_src1); else pass_cnt++;
        end
        exp_stall += 3;
        chk_cnt++; if (stall_cycles !== 32'(exp_stall)) $display("FAIL frz_cnt: got %0d want %0d", stall_cycles, exp_stall); else pass_cnt++;
        mem_ready = 1'b1;
        mid();
        chk_cnt++; if ({freeze, stall_if, bubble_ex} !== 3'b011)
            $display("FAIL frz_then_lu: got %b want 011", {freeze, stall_if, bubble_ex}); else pass_cnt++;
        tick();
        exp_stall++;
        chk_cnt++; if (stall_cycles !== 32'(exp_stall)) $display("FAIL frz_lu_cnt: got %0d want %0d", stall_cycles, exp_stall); else pass_cnt++;
        tick();
        chk_cnt++; if ({fwd_sel_src1, fwd_sel_src2} !== {3'd2, 3'd2})
            $display("FAIL frz_after_sel: got %0d,%0d want 2,2", fwd_sel_src1, fwd_sel_src2); else pass_cnt++;
    endtask

    task automatic test_saturate();
        drain();
        mem_ready = 1'b0;
        repeat (4) tick();
        mem_ready = 1'b1;
        exp_stall += 4;
        exp_sat = (exp_stall > 7) ? 7 : exp_stall;
        chk_cnt++; if (stall_cycles !== 32'(exp_stall)) $display("FAIL sat_main_cnt: got %0d want %0d", stall_cycles, exp_stall); else pass_cnt++;
        chk_cnt++; if (sat_cycles !== 3'(exp_sat)) $display("FAIL sat_cnt: got %0d want %0d", sat_cycles, exp_sat); else pass_cnt++;
        tick();
        chk_cnt++; if (sat_cycles !== 3'd7) $display("FAIL sat_hold: got %0d want 7", sat_cycles); else pass_cnt++;
    endtask

    task automatic test_reset_mid_stall();
        drain();
        alu(5, 1, 2); tick();
        load(9, 5); tick();
        alu(6, 9, 9);
        mid();
        chk_cnt++; if (stall_if !== 1'b1) $display("FAIL rms_pre_stall: got %b want 1", stall_if); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        chk_cnt++; if (fwd_sel_src1 !== 3'd0) $display("FAIL rms_sel1: got %0d want 0", fwd_sel_src1); else pass_cnt++;
        chk_cnt++; if (stall_cycles !== 32'd0) $display("FAIL rms_cnt: got %0d want 0", stall_cycles); else pass_cnt++;
        chk_cnt++; if ({stall_if, bubble_ex} !== 2'b00) $display("FAIL rms_ctl: got %b want 00", {stall_if, bubble_ex}); else pass_cnt++;
        mem_ready = 1'b0;
        #1;
        chk_cnt++; if ({freeze, stall_if} !== 2'b11) $display("FAIL rms_freeze: got %b want 11", {freeze, stall_if}); else pass_cnt++;
        mem_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_cnt++; if (fwd_sel_src1 !== 3'd0) $display("FAIL rms_post_sel: got %0d want 0", fwd_sel_src1); else pass_cnt++;
        chk_cnt++; if (stall_cycles !== 32'd0) $display("FAIL rms_post_cnt: got %0d want 0", stall_cycles); else pass_cnt++;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        pass_cnt        = 0;
        chk_cnt         = 0;
        exp_stall       = 0;
        exp_sat         = 0;
        rst_n           = 1'b0;
        ex_branch_taken = 1'b0;
        mem_ready       = 1'b1;
        nop();

        test_reset();
        test_back_to_back();
        test_gap();
        test_load_use();
        test_x0_and_dual();
        test_branch_flush();
        test_freeze();
        test_saturate();
        test_reset_mid_stall();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
